// File: rtl/turbo_enc_pkg.sv
// Shared sizes, interleaver table, FSM encoding and BPSK constants for the turbo encoder.
// The BPSK bit-plane helper is only used when TURBO_ENC_BITPLANE_TX_EN is defined.
package turbo_pkg;

  localparam int INPUT_SIZE  = 5;
  localparam int EXTEND_SIZE = 7;
  localparam int BLOCK_SIZE  = 21;
  localparam int SOFT_W      = 4;

  localparam logic [2:0] ILV_IDX [INPUT_SIZE] = '{3'd0, 3'd4, 3'd2, 3'd1, 3'd3};

  localparam logic [SOFT_W-1:0] BPSK_ONE  = 4'b0111;
  localparam logic [SOFT_W-1:0] BPSK_ZERO = 4'b1001;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENC   = 3'd1,
    S_TAIL  = 3'd2,
    S_OUT   = 3'd3,
    S_PLANE = 3'd4
  } state_e;

  // Info bit u_k, where u0 is the MSB of the block
  function automatic logic info_bit(input logic [INPUT_SIZE-1:0] d, input logic [2:0] k);
    case (k)
      3'd0:    return d[4];
      3'd1:    return d[3];
      3'd2:    return d[2];
      3'd3:    return d[1];
      3'd4:    return d[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] ilv_idx(input logic [2:0] step);
    if (step < 3'd5) return ILV_IDX[step];
    else             return 3'd0;
  endfunction

  // Bit k of the BPSK symbol of every coded bit, same positions as the hard frame
  function automatic logic [BLOCK_SIZE-1:0] bpsk_plane(input logic [BLOCK_SIZE-1:0] hard,
                                                       input logic [1:0] k);
    logic [BLOCK_SIZE-1:0] plane;
    logic [SOFT_W-1:0]     sym;
    plane = {BLOCK_SIZE{1'b0}};
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      sym      = hard[i] ? BPSK_ONE : BPSK_ZERO;
      plane[i] = sym[k];
    end
    return plane;
  endfunction

endpackage

// File: rtl/turbo_enc_rsc.sv
// 4-state recursive systematic convolutional encoder core (feedback 1+D+D^2, forward 1+D^2).
// In tail mode the input is forced to s1^s2 so the register flushes to 00 in two steps.
module rsc_enc_core (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_clear,
  input  logic       i_step,
  input  logic       i_tail,
  input  logic       i_u,
  output logic       o_sys,
  output logic       o_par,
  output logic [1:0] o_state
);

  logic [1:0] r_state;
  logic       w_u;
  logic       w_a;

  assign w_u     = i_tail ? (r_state[1] ^ r_state[0]) : i_u;
  assign w_a     = w_u ^ r_state[1] ^ r_state[0];
  assign o_sys   = w_u;
  assign o_par   = w_a ^ r_state[0];
  assign o_state = r_state;

  // Trellis state register {s1, s2}
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)  r_state <= 2'b00;
    else if (i_clear) r_state <= 2'b00;
    else if (i_step)  r_state <= {w_a, r_state[1]};
    else              r_state <= r_state;
  end

endmodule

// File: rtl/turbo_enc.sv
// Rate-1/3 turbo encoder: 5 info bits -> 21-bit {sys, par1, par2} frame, 2 tail steps per trellis.
// Build option TURBO_ENC_BITPLANE_TX_EN replaces the single output beat with 4 BPSK bit-plane beats.
module turbo_enc
  import turbo_pkg::*;
(
  input  logic                  clk_p_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic [INPUT_SIZE-1:0] data_i,
  output logic [BLOCK_SIZE-1:0] data_o,
  output logic                  valid_o,
  output logic                  done_o,
  output logic                  busy_o
);

  state_e                  r_fsm;
  logic [2:0]              r_step;
  logic [INPUT_SIZE-1:0]   r_data;
  logic [EXTEND_SIZE-1:0]  r_sys;
  logic [EXTEND_SIZE-1:0]  r_p1;
  logic [EXTEND_SIZE-1:0]  r_p2;
  logic [BLOCK_SIZE-1:0]   r_data_o;
  logic                    r_valid;
  logic                    r_done;
  logic                    r_busy;
`ifdef TURBO_ENC_BITPLANE_TX_EN
  logic [1:0]              r_plane;
`endif

  logic       w_clear;
  logic       w_step;
  logic       w_tail;
  logic       w_u1;
  logic       w_u2;
  logic       w_sys1;
  logic       w_par1;
  logic       w_sys2;
  logic       w_par2;
  logic [1:0] w_st1;
  logic [1:0] w_st2;
  logic       w_unused_ok;

  assign w_clear = (r_fsm == S_IDLE) && start_i;
  assign w_step  = (r_fsm == S_ENC) || (r_fsm == S_TAIL);
  assign w_tail  = (r_fsm == S_TAIL);
  assign w_u1    = info_bit(r_data, r_step);
  assign w_u2    = info_bit(r_data, ilv_idx(r_step));
  // Encoder 2 tail systematic bits are never transmitted; states are observation-only
  assign w_unused_ok = ^{w_sys2, w_st1, w_st2};

  rsc_enc_core u_enc1 (
    .i_clk     (clk_p_i),
    .i_reset_n (reset_n_i),
    .i_clear   (w_clear),
    .i_step    (w_step),
    .i_tail    (w_tail),
    .i_u       (w_u1),
    .o_sys     (w_sys1),
    .o_par     (w_par1),
    .o_state   (w_st1)
  );

  rsc_enc_core u_enc2 (
    .i_clk     (clk_p_i),
    .i_reset_n (reset_n_i),
    .i_clear   (w_clear),
    .i_step    (w_step),
    .i_tail    (w_tail),
    .i_u       (w_u2),
    .o_sys     (w_sys2),
    .o_par     (w_par2),
    .o_state   (w_st2)
  );

  // Block sequencing, stream accumulation and registered outputs
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_fsm    <= S_IDLE;
      r_step   <= 3'd0;
      r_data   <= 5'd0;
      r_sys    <= 7'd0;
      r_p1     <= 7'd0;
      r_p2     <= 7'd0;
      r_data_o <= 21'd0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
`ifdef TURBO_ENC_BITPLANE_TX_EN
      r_plane  <= 2'd0;
`endif
    end else begin
      case (r_fsm)
        S_IDLE: begin
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          if (start_i) begin
            r_data <= data_i;
            r_step <= 3'd0;
            r_sys  <= 7'd0;
            r_p1   <= 7'd0;
            r_p2   <= 7'd0;
            r_busy <= 1'b1;
            r_fsm  <= S_ENC;
          end else begin
            r_fsm  <= S_IDLE;
          end
        end
        S_ENC, S_TAIL: begin
          // Step j lands at bit 6-j once all 7 steps have shifted in
          r_sys  <= {r_sys[5:0], w_sys1};
          r_p1   <= {r_p1[5:0], w_par1};
          r_p2   <= {r_p2[5:0], w_par2};
          r_step <= r_step + 3'd1;
          if (r_step == 3'd4) begin
            r_fsm <= S_TAIL;
          end else if (r_step == 3'd6) begin
`ifdef TURBO_ENC_BITPLANE_TX_EN
            r_plane <= 2'd0;
            r_fsm   <= S_PLANE;
`else
            r_fsm   <= S_OUT;
`endif
          end else begin
            r_fsm <= r_fsm;
          end
        end
        S_OUT: begin
          r_data_o <= {r_sys, r_p1, r_p2};
          r_valid  <= 1'b1;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_fsm    <= S_IDLE;
        end
`ifdef TURBO_ENC_BITPLANE_TX_EN
        S_PLANE: begin
          r_data_o <= bpsk_plane({r_sys, r_p1, r_p2}, r_plane);
          r_valid  <= 1'b1;
          r_plane  <= r_plane + 2'd1;
          if (r_plane == 2'd3) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_fsm  <= S_IDLE;
          end else begin
            r_fsm  <= S_PLANE;
          end
        end
`endif
        default: begin
          r_fsm <= S_IDLE;
        end
      endcase
    end
  end

  assign data_o  = r_data_o;
  assign valid_o = r_valid;
  assign done_o  = r_done;
  assign busy_o  = r_busy;

endmodule

// File: tb/tb_turbo_enc.sv
// Self-checking bench for turbo_enc: directed frames, latency, start filtering, mid-block reset,
// random blocks against a reference encoder, and the bit-plane output when that option is built.
module tb_turbo_enc;

  logic        clk_p_i   = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        start_i   = 1'b0;
  logic [4:0]  data_i    = 5'd0;
  logic [20:0] data_o;
  logic        valid_o;
  logic        done_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

`ifdef TURBO_ENC_BITPLANE_TX_EN
  localparam int LAT    = 11;
  localparam int NBEATS = 4;
`else
  localparam int LAT    = 8;
  localparam int NBEATS = 1;
`endif
  localparam logic [20:0] VEC_FRAME = 21'b1011010_1100110_1101100;

  turbo_enc dut (
    .clk_p_i   (clk_p_i),
    .reset_n_i (reset_n_i),
    .start_i   (start_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .done_o    (done_o),
    .busy_o    (busy_o)
  );

  always #5 clk_p_i = ~clk_p_i;

  logic [20:0] planes [4];
  logic [20:0] got_frame;
  logic [20:0] got_first;
  logic [3:0]  got_st;
  int          got_lat;
  int          got_beats;
  int          got_vlat;

  // Returns {sys[6:0], par[6:0]} for one RSC run; u[4] is the first input
  function automatic logic [13:0] ref_rsc(input logic [4:0] u);
    logic [6:0] sys;
    logic [6:0] par;
    logic s1, s2, b, a;
    s1 = 1'b0;
    s2 = 1'b0;
    for (int j = 0; j < 7; j++) begin
      if (j < 5) b = u[4-j];
      else       b = s1 ^ s2;
      a          = b ^ s1 ^ s2;
      sys[6-j]   = b;
      par[6-j]   = a ^ s2;
      s2         = s1;
      s1         = a;
    end
    return {sys, par};
  endfunction

  function automatic logic [20:0] ref_frame(input logic [4:0] d);
    logic [13:0] r1;
    logic [13:0] r2;
    r1 = ref_rsc(d);
    r2 = ref_rsc({d[4], d[0], d[2], d[3], d[1]});
    return {r1[13:7], r1[6:0], r2[6:0]};
  endfunction

  // Starts one block; optionally raises start_i again after edge inj_at (counted from the accepting edge)
  task automatic run_block(input logic [4:0] d, input int inj_at, input logic [4:0] inj_d);
    @(negedge clk_p_i);
    start_i = 1'b1;
    data_i  = d;
    @(posedge clk_p_i);
    #1;
    start_i   = 1'b0;
    got_lat   = -1;
    got_beats = 0;
    got_vlat  = -1;
    got_first = data_o;
    got_st    = 4'hF;
    for (int n = 1; n <= 40; n++) begin
      if (n - 1 == inj_at) begin
        start_i = 1'b1;
        data_i  = inj_d;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk_p_i);
      #1;
      if (valid_o) begin
        if (got_vlat < 0) got_vlat = n;
        if (got_beats < 4) planes[got_beats] = data_o;
        got_beats++;
      end
      if (done_o) begin
        got_lat = n;
        got_st  = {dut.u_enc1.o_state, dut.u_enc2.o_state};
        break;
      end
    end
    start_i = 1'b0;
`ifdef TURBO_ENC_BITPLANE_TX_EN
    got_frame = planes[1];
`else
    got_frame = data_o;
`endif
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({data_o, valid_o, done_o, busy_o} !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b d=%b b=%b, want all zero", data_o, valid_o, done_o, busy_o);
    end
    checks++;
    if ({dut.u_enc1.o_state, dut.u_enc2.o_state} !== 4'd0) begin
      errors++;
      $display("FAIL reset_states: got %b, want 0000", {dut.u_enc1.o_state, dut.u_enc2.o_state});
    end
    repeat (2) @(negedge clk_p_i);
    reset_n_i = 1'b1;
    @(negedge clk_p_i);
  endtask

  task automatic test_zero_block();
    run_block(5'b00000, -1, 5'd0);
    checks++;
    if (got_lat !== LAT) begin
      errors++;
      $display("FAIL zero_latency: got %0d, want %0d", got_lat, LAT);
    end
    checks++;
    if (got_frame !== 21'h000000) begin
      errors++;
      $display("FAIL zero_frame: got %h, want 000000", got_frame);
    end
    checks++;
    if (got_vlat !== LAT - NBEATS + 1 || got_beats !== NBEATS) begin
      errors++;
      $display("FAIL zero_beats: got first=%0d n=%0d, want first=%0d n=%0d", got_vlat, got_beats, LAT - NBEATS + 1, NBEATS);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_busy_clear: got %b, want 0", busy_o);
    end
  endtask

  task automatic test_vector();
    run_block(5'b10110, -1, 5'd0);
    checks++;
    if (got_frame !== VEC_FRAME) begin
      errors++;
      $display("FAIL vector_frame: got %b, want %b", got_frame, VEC_FRAME);
    end
    checks++;
    if (got_st !== 4'b0000) begin
      errors++;
      $display("FAIL vector_states: got %b, want 0000", got_st);
    end
    checks++;
    if (got_lat !== LAT) begin
      errors++;
      $display("FAIL vector_latency: got %0d, want %0d", got_lat, LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] prev;
    run_block(5'b10110, 3, 5'b11111);
    checks++;
    if (got_frame !== VEC_FRAME || got_lat !== LAT) begin
      errors++;
      $display("FAIL b2b_ignored: got %b lat %0d, want %b lat %0d", got_frame, got_lat, VEC_FRAME, LAT);
    end
    run_block(5'b01001, LAT - 1, 5'b11111);
    checks++;
    if (got_frame !== ref_frame(5'b01001)) begin
      errors++;
      $display("FAIL b2b_second: got %b, want %b", got_frame, ref_frame(5'b01001));
    end
    @(posedge clk_p_i);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_out_start_ignored: busy got %b, want 0", busy_o);
    end
    prev = data_o;
    run_block(5'b11111, -1, 5'd0);
    checks++;
    if (got_first !== prev) begin
      errors++;
      $display("FAIL b2b_hold: got %h, want %h", got_first, prev);
    end
    checks++;
    if (got_frame !== ref_frame(5'b11111)) begin
      errors++;
      $display("FAIL b2b_fresh: got %b, want %b", got_frame, ref_frame(5'b11111));
    end
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    @(negedge clk_p_i);
    start_i = 1'b1;
    data_i  = 5'b10110;
    @(posedge clk_p_i);
    #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_p_i);
    #1;
    reset_n_i = 1'b0;
    #1;
    checks++;
    if ({data_o, valid_o, done_o, busy_o} !== 24'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got data=%h v=%b d=%b b=%b, want all zero", data_o, valid_o, done_o, busy_o);
    end
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk_p_i);
      #1;
      if (done_o !== 1'b0) seen_done = 1'b1;
    end
    @(negedge clk_p_i);
    reset_n_i = 1'b1;
    repeat (12) begin
      @(posedge clk_p_i);
      #1;
      if (done_o !== 1'b0 || valid_o !== 1'b0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_done: got done/valid seen=%b, want 0", seen_done);
    end
    run_block(5'b10110, -1, 5'd0);
    checks++;
    if (got_frame !== VEC_FRAME) begin
      errors++;
      $display("FAIL midreset_restart: got %b, want %b", got_frame, VEC_FRAME);
    end
  endtask

  task automatic test_random();
    logic [4:0] d;
    for (int i = 0; i < 200; i++) begin
      d = 5'($urandom_range(0, 31));
      run_block(d, -1, 5'd0);
      checks++;
      if (got_frame !== ref_frame(d) || got_lat !== LAT || got_st !== 4'b0000) begin
        errors++;
        $display("FAIL random_%0d: data %b got %b lat %0d st %b, want %b lat %0d st 0000",
                 i, d, got_frame, got_lat, got_st, ref_frame(d), LAT);
      end
    end
  endtask

`ifdef TURBO_ENC_BITPLANE_TX_EN
  task automatic test_bitplane();
    run_block(5'b10110, -1, 5'd0);
    checks++;
    if (planes[0] !== 21'h1FFFFF) begin
      errors++;
      $display("FAIL plane0: got %b, want all ones", planes[0]);
    end
    checks++;
    if (planes[1] !== VEC_FRAME || planes[2] !== VEC_FRAME) begin
      errors++;
      $display("FAIL plane12: got %b %b, want %b", planes[1], planes[2], VEC_FRAME);
    end
    checks++;
    if (planes[3] !== ~VEC_FRAME) begin
      errors++;
      $display("FAIL plane3: got %b, want %b", planes[3], ~VEC_FRAME);
    end
    checks++;
    if (got_beats !== 4 || got_vlat !== 8 || got_lat !== 11) begin
      errors++;
      $display("FAIL plane_beats: got n=%0d first=%0d done=%0d, want 4 8 11", got_beats, got_vlat, got_lat);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_block();
    test_vector();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef TURBO_ENC_BITPLANE_TX_EN
    test_bitplane();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
